// File: rtl/qrd_delay_pkg.sv
// Shared constants and helpers for the QRD-RLS alignment delay lines.
// The default delay is also used by the array cell latency budgets.
package qrd_delay_pkg;

  localparam int QRD_DEFAULT_DELAY = 20;

  // Per-cycle control decoded once in the top and fanned out to every lane.
  typedef struct packed {
    logic clear;
    logic shift;
    logic load;
  } line_ctl_t;

  function automatic int calc_dw(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  function automatic logic delay_out_of_range(input logic [31:0] req, input logic [31:0] max_d);
    return (req == 32'd0) || (req > max_d);
  endfunction

  function automatic logic [31:0] clamp_delay(input logic [31:0] req, input logic [31:0] max_d);
    if (req == 32'd0) return 32'd1;
    if (req > max_d)  return max_d;
    return req;
  endfunction

endpackage

// File: rtl/delay_tap_line.sv
// One lane of the delay line: DEPTH-stage shift register with clear and a
// selectable output tap, gated to zero when the shared valid tap is low.
module delay_tap_line #(
  parameter int W     = 8,
  parameter int DEPTH = 20,
  parameter int SW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift,
  input  logic          clear,
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] tap_sel,
  input  logic          tap_en,
  output logic [W-1:0]  dout
);

  logic [DEPTH:1][W-1:0] stg_q, stg_d;
  logic [W-1:0]          tap;

  always_comb begin
    stg_d = stg_q;
    if (clear) begin
      stg_d = '0;
    end else if (shift) begin
      stg_d[1] = din;
      for (int i = 2; i <= DEPTH; i++) stg_d[i] = stg_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stg_q <= '0;
    else        stg_q <= stg_d;
  end

  // tap_sel is held in 1..DEPTH by the config register; other codes read zero.
  always_comb begin
    tap = '0;
    for (int i = 1; i <= DEPTH; i++)
      if (tap_sel == SW'(i)) tap = stg_q[i];
  end

  assign dout = tap_en ? tap : '0;

endmodule

// File: rtl/delay_line_prog.sv
// Multi-lane run-time programmable alignment delay line with stall, flush,
// clamped delay loading and a primed flag for discarding start-up garbage.
module delay_line_prog
  import qrd_delay_pkg::*;
#(
  parameter  int NCH           = 4,
  parameter  int DATA_LENGTH   = 8,
  parameter  int MAX_DELAY     = 20,
  parameter  int DEFAULT_DELAY = QRD_DEFAULT_DELAY,
  localparam int DW            = calc_dw(MAX_DELAY)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic [NCH*DATA_LENGTH-1:0] din,
  input  logic                       din_valid,
  input  logic                       flush,
  input  logic                       cfg_load,
  input  logic [DW-1:0]              cfg_delay,
  output logic [NCH*DATA_LENGTH-1:0] dout,
  output logic                       dout_valid,
  output logic                       primed,
  output logic                       cfg_err,
  output logic [DW-1:0]              cur_delay
);

  line_ctl_t ctl;

  logic [MAX_DELAY:1] vld_pipe_q, vld_pipe_d;
  logic [DW-1:0]      cur_delay_q, cur_delay_d;
  logic [DW-1:0]      fill_q, fill_d;
  logic               primed_q, primed_d;
  logic               cfg_err_q, cfg_err_d;
  logic               vld_tap;

  logic [NCH-1:0][DATA_LENGTH-1:0] din_lanes, dout_lanes;

  assign din_lanes = din;
  assign dout      = dout_lanes;

  // cfg_load implies a clear; either clear suppresses the shift that cycle.
  always_comb begin
    ctl.load  = cfg_load;
    ctl.clear = cfg_load | flush;
    ctl.shift = ce & ~(cfg_load | flush);
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (ctl.clear) begin
      vld_pipe_d = '0;
    end else if (ctl.shift) begin
      vld_pipe_d[1] = din_valid;
      for (int i = 2; i <= MAX_DELAY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end
  end

  always_comb begin
    cur_delay_d = cur_delay_q;
    cfg_err_d   = 1'b0;
    if (ctl.load) begin
      cur_delay_d = DW'(clamp_delay(32'(cfg_delay), 32'(MAX_DELAY)));
      cfg_err_d   = delay_out_of_range(32'(cfg_delay), 32'(MAX_DELAY));
    end
  end

  // Fill counts shifts since the last clear, saturating at the delay in force.
  always_comb begin
    fill_d = fill_q;
    if (ctl.clear)
      fill_d = '0;
    else if (ctl.shift && (fill_q < cur_delay_q))
      fill_d = fill_q + DW'(1);
    primed_d = (fill_d == cur_delay_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      cur_delay_q <= DW'(DEFAULT_DELAY);
      fill_q      <= '0;
      primed_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      cur_delay_q <= cur_delay_d;
      fill_q      <= fill_d;
      primed_q    <= primed_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_comb begin
    vld_tap = 1'b0;
    for (int i = 1; i <= MAX_DELAY; i++)
      if (cur_delay_q == DW'(i)) vld_tap = vld_pipe_q[i];
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    delay_tap_line #(
      .W     (DATA_LENGTH),
      .DEPTH (MAX_DELAY),
      .SW    (DW)
    ) u_tap (
      .clk     (clk),
      .rst_n   (rst_n),
      .shift   (ctl.shift),
      .clear   (ctl.clear),
      .din     (din_lanes[k]),
      .tap_sel (cur_delay_q),
      .tap_en  (vld_tap),
      .dout    (dout_lanes[k])
    );
  end

  assign dout_valid = vld_tap;
  assign primed     = primed_q;
  assign cfg_err    = cfg_err_q;
  assign cur_delay  = cur_delay_q;

endmodule
